// File: rtl/led_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : led_pkg                                                       |
// | Purpose  : Shared definitions for the LED indicator bank: the 2-bit      |
// |            per-channel mode codes and the status-code activity test.     |
// | Contents : LED_OFF / LED_STEADY / LED_BLINK / LED_PULSE,                 |
// |            is_active(code, idle)                                         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package led_pkg;

  localparam logic [1:0] LED_OFF    = 2'b00;
  localparam logic [1:0] LED_STEADY = 2'b01;
  localparam logic [1:0] LED_BLINK  = 2'b10;
  localparam logic [1:0] LED_PULSE  = 2'b11;

  // A status code is inactive when it is zero or equal to the idle code.
  // Arguments are 32 bits wide so that any SRC_W up to 32 can be passed
  // after zero-extension at the call site.
  function automatic logic is_active(input logic [31:0] code,
                                     input logic [31:0] idle);
    return (code != 32'd0) && (code != idle);
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_indicator_bank_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : led_bank_if                                                   |
// | Purpose  : Bundles the status/mode/brightness inputs and the LED drive   |
// |            output of the indicator bank.                                 |
// | Ports    : iValue  CHANNELS*SRC_W  status codes, channel c at c*SRC_W    |
// |            iMode   2*CHANNELS      per-channel mode, channel c at 2c     |
// |            iBright PWM_W           global brightness                     |
// |            oLights CHANNELS        registered LED drive                  |
// |            master: drives codes/modes/brightness, reads lights           |
// |            slave : the bank itself                                       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface led_bank_if #(
  parameter int CHANNELS = 8,
  parameter int SRC_W    = 8,
  parameter int PWM_W    = 4
) ();

  logic [CHANNELS*SRC_W-1:0] iValue;
  logic [2*CHANNELS-1:0]     iMode;
  logic [PWM_W-1:0]          iBright;
  logic [CHANNELS-1:0]       oLights;

  modport master (
    output iValue,
    output iMode,
    output iBright,
    input  oLights
  );

  modport slave (
    input  iValue,
    input  iMode,
    input  iBright,
    output oLights
  );

endinterface
`default_nettype wire

// File: rtl/led_channel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : led_channel                                                   |
// | Purpose  : One indicator channel: registered activity flag, registered   |
// |            copy of the status code, pulse-stretch counter, mode mux and  |
// |            the output flop.                                              |
// | Ports    : iClk, iReset        clock, async active-high reset            |
// |            value_i  SRC_W      status code for this channel              |
// |            mode_i   2          OFF/STEADY/BLINK/PULSE                    |
// |            blink_phase_i 1     shared blink phase                        |
// |            gate_i   1          shared PWM brightness gate                |
// |            light_o  1          registered LED drive                      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module led_channel
  import led_pkg::*;
#(
  parameter int SRC_W          = 8,
  parameter int IDLE_CODE      = 99,
  parameter int STRETCH_CYCLES = 5000000
) (
  input  logic             iClk,
  input  logic             iReset,
  input  logic [SRC_W-1:0] value_i,
  input  logic [1:0]       mode_i,
  input  logic             blink_phase_i,
  input  logic             gate_i,
  output logic             light_o
);

  localparam int              CNT_W        = $clog2(STRETCH_CYCLES + 1);
  localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(STRETCH_CYCLES);

  logic             act_d, act_q;
  logic [SRC_W-1:0] value_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             on_w;
  logic             light_d, light_q;

  always_comb begin
    act_d = is_active(32'(value_i), 32'(IDLE_CODE));

    // Outside PULSE the counter is held at zero, so entering PULSE never
    // replays an old event. A new event reloads rather than extends.
    cnt_d = '0;
    if (mode_i == LED_PULSE) begin
      if (act_d && (!act_q || (value_i != value_q))) begin
        cnt_d = STRETCH_LOAD;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    on_w = 1'b0;
    case (mode_i)
      LED_STEADY: on_w = act_q;
      LED_BLINK:  on_w = act_q & blink_phase_i;
      LED_PULSE:  on_w = (cnt_q != '0);
      default:    on_w = 1'b0;
    endcase

    light_d = on_w & gate_i;
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      act_q   <= 1'b0;
      value_q <= '0;
      cnt_q   <= '0;
      light_q <= 1'b0;
    end else begin
      act_q   <= act_d;
      value_q <= value_i;
      cnt_q   <= cnt_d;
      light_q <= light_d;
    end
  end

  assign light_o = light_q;

endmodule
`default_nettype wire

// File: rtl/led_indicator_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : led_indicator_bank                                            |
// | Purpose  : CHANNELS status LEDs, each OFF/STEADY/BLINK/PULSE, with one   |
// |            global PWM brightness gate. Holds the shared blink prescaler  |
// |            and PWM counter; per-channel state lives in led_channel.      |
// | Ports    : iClk    system clock                                          |
// |            iReset  asynchronous active-high reset                        |
// |            bus     led_bank_if.slave (iValue, iMode, iBright, oLights)   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module led_indicator_bank
  import led_pkg::*;
#(
  parameter int CHANNELS       = 8,
  parameter int SRC_W          = 8,
  parameter int IDLE_CODE      = 99,
  parameter int BLINK_DIV      = 25000000,
  parameter int STRETCH_CYCLES = 5000000,
  parameter int PWM_W          = 4
) (
  input  logic      iClk,
  input  logic      iReset,
  led_bank_if.slave bus
);

  localparam int               BLK_W    = $clog2(BLINK_DIV);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [BLK_W-1:0]    presc_d, presc_q;
  logic                phase_d, phase_q;
  logic [PWM_W-1:0]    pwm_d, pwm_q;
  logic                gate_w;
  logic [CHANNELS-1:0] lights_w;

  always_comb begin
    // Phase flips on the wrap cycle, so the first lit half-period begins
    // BLINK_DIV cycles after reset.
    if (presc_q == BLK_LAST) begin
      presc_d = '0;
      phase_d = ~phase_q;
    end else begin
      presc_d = presc_q + BLK_W'(1);
      phase_d = phase_q;
    end

    pwm_d = pwm_q + PWM_W'(1);

    // All-ones must be fully on; a plain compare would leave one dark slot.
    gate_w = (bus.iBright == {PWM_W{1'b1}}) | (pwm_q < bus.iBright);
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      presc_q <= '0;
      phase_q <= 1'b0;
      pwm_q   <= '0;
    end else begin
      presc_q <= presc_d;
      phase_q <= phase_d;
      pwm_q   <= pwm_d;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    led_channel #(
      .SRC_W          (SRC_W),
      .IDLE_CODE      (IDLE_CODE),
      .STRETCH_CYCLES (STRETCH_CYCLES)
    ) u_channel (
      .iClk          (iClk),
      .iReset        (iReset),
      .value_i       (bus.iValue[c*SRC_W +: SRC_W]),
      .mode_i        (bus.iMode[2*c +: 2]),
      .blink_phase_i (phase_q),
      .gate_i        (gate_w),
      .light_o       (lights_w[c])
    );
  end

  assign bus.oLights = lights_w;

endmodule
`default_nettype wire

// File: tb/tb_led_indicator_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_led_indicator_bank                                         |
// | Purpose  : Self-checking bench for led_indicator_bank with a scoreboard  |
// |            fed by a cycle-level reference model of the LED rules.        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_led_indicator_bank;

  localparam int CH   = 8;
  localparam int SW   = 8;
  localparam int IDLE = 99;
  localparam int BD   = 4;
  localparam int SC   = 6;
  localparam int PW   = 4;

  logic iClk = 1'b0;
  logic iReset;

  always #5 iClk = ~iClk;

  led_bank_if #(.CHANNELS(CH), .SRC_W(SW), .PWM_W(PW)) bus ();

  led_indicator_bank #(
    .CHANNELS       (CH),
    .SRC_W          (SW),
    .IDLE_CODE      (IDLE),
    .BLINK_DIV      (BD),
    .STRETCH_CYCLES (SC),
    .PWM_W          (PW)
  ) dut (
    .iClk   (iClk),
    .iReset (iReset),
    .bus    (bus)
  );

  // Reference model state: n counts clock edges since reset release;
  // last_ev holds the edge of the latest pulse event (0 = none).
  int         n;
  int         last_ev [CH];
  int         pval    [CH];
  bit         pact    [CH];
  logic [7:0] exp_q   [$];
  logic [7:0] obs;
  int         tests = 0;
  int         fails = 0;

  function automatic bit act(input int v);
    return (v != 0) && (v != IDLE);
  endfunction

  task automatic model_reset();
    n = 0;
    for (int c = 0; c < CH; c++) begin
      last_ev[c] = 0;
      pval[c]    = 0;
      pact[c]    = 1'b0;
    end
  endtask

  // Called at a negedge: drive inputs, predict the lights after the
  // next posedge, then advance to the following negedge.
  task automatic step(input logic [63:0] v, input logic [15:0] m,
                      input logic [3:0] b);
    logic [7:0] e;
    bit gate, phase, on;
    int val, md;
    bus.iValue  = v;
    bus.iMode   = m;
    bus.iBright = b;
    n++;
    gate  = (b == 4'hF) || (((n - 1) % 16) < int'(b));
    phase = (((n - 1) / BD) % 2) == 1;
    e = '0;
    for (int c = 0; c < CH; c++) begin
      val = int'(v[c*8 +: 8]);
      md  = int'(m[2*c +: 2]);
      case (md)
        1:       on = pact[c];
        2:       on = pact[c] && phase;
        3:       on = (last_ev[c] > 0) && ((n - last_ev[c]) <= SC);
        default: on = 1'b0;
      endcase
      e[c] = on && gate;
      if (md != 3) last_ev[c] = 0;
      else if (act(val) && (!pact[c] || val != pval[c])) last_ev[c] = n;
      pact[c] = act(val);
      pval[c] = val;
    end
    exp_q.push_back(e);
    @(negedge iClk);
  endtask

  // Monitor: compare each registered output against the queued prediction.
  always @(posedge iClk) begin
    logic [7:0] ex;
    #1;
    if (!iReset && exp_q.size() > 0) begin
      ex  = exp_q.pop_front();
      obs = bus.oLights;
      tests++;
      if (obs !== ex) begin
        fails++;
        $display("FAIL lights edge %0d: got %02h expected %02h", n, obs, ex);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int          lit;
  int          cur [CH];
  logic [15:0] rm;
  logic [63:0] rv;
  logic [3:0]  rb;

  task automatic random_steps(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(3) == 0) begin
          case ($urandom_range(3))
            0:       cur[c] = 0;
            1:       cur[c] = IDLE;
            default: cur[c] = int'($urandom_range(255));
          endcase
        end
        rv[c*8 +: 8] = 8'(cur[c]);
      end
      if ($urandom_range(15) == 0) rm = 16'($urandom());
      if ($urandom_range(31) == 0) rb = ($urandom_range(1) == 0) ? 4'hF : 4'($urandom());
      step(rv, rm, rb);
    end
  endtask

  initial begin
    iReset      = 1'b1;
    bus.iValue  = '0;
    bus.iMode   = '0;
    bus.iBright = 4'hF;
    model_reset();
    check("reset_lights", int'(bus.oLights), 0);
    repeat (3) @(negedge iClk);
    iReset = 1'b0;

    // Reset behaviour: all-zero codes keep the bank dark in every mode.
    for (int k = 0; k < 6; k++) step('0, 16'($urandom()), 4'hF);

    // STEADY on channel 0: 0 -> 5 -> 99 -> 5 -> 0.
    repeat (3) step(64'h0,  16'h0001, 4'hF);
    repeat (4) step(64'h05, 16'h0001, 4'hF);
    repeat (4) step(64'h63, 16'h0001, 4'hF);
    repeat (3) step(64'h05, 16'h0001, 4'hF);
    repeat (4) step(64'h0,  16'h0001, 4'hF);

    // BLINK on channel 1 with code 7, then inactive.
    repeat (20) step(64'h0700, 16'h0008, 4'hF);
    repeat (6)  step(64'h0,    16'h0008, 4'hF);

    // PULSE on channel 2: one-cycle event gives exactly SC lit cycles.
    lit = 0;
    repeat (3) step(64'h0, 16'h0030, 4'hF);
    step(64'h03_0000, 16'h0030, 4'hF);
    for (int k = 0; k < 12; k++) begin
      step(64'h0, 16'h0030, 4'hF);
      lit += int'(obs[2]);
    end
    check("pulse_lit_count", lit, SC);
    // Retrigger by code change partway through the pulse.
    repeat (2)  step(64'h0,       16'h0030, 4'hF);
    repeat (4)  step(64'h03_0000, 16'h0030, 4'hF);
    repeat (10) step(64'h04_0000, 16'h0030, 4'hF);
    // Mode to OFF mid-pulse.
    repeat (2) step(64'h0,       16'h0030, 4'hF);
    repeat (3) step(64'h05_0000, 16'h0030, 4'hF);
    repeat (4) step(64'h05_0000, 16'h0000, 4'hF);
    repeat (3) step(64'h05_0000, 16'h0030, 4'hF);

    // PWM on channel 3 (STEADY, active).
    repeat (4) step(64'h11_00_0000, 16'h0040, 4'd4);
    lit = 0;
    for (int k = 0; k < 16; k++) begin
      step(64'h11_00_0000, 16'h0040, 4'd4);
      lit += int'(obs[3]);
    end
    check("pwm_duty_4_of_16", lit, 4);
    repeat (18) step(64'h11_00_0000, 16'h0040, 4'd0);
    repeat (6)  step(64'h11_00_0000, 16'h0040, 4'hF);

    // Mixed modes on all channels.
    for (int c = 0; c < CH; c++) cur[c] = 0;
    rm = 16'($urandom());
    rb = 4'hF;
    random_steps(200);

    // Reset asserted mid-cycle with lights on and random codes.
    repeat (6) step(64'h0101_0101_0101_0101, 16'h5555, 4'hF);
    @(posedge iClk);
    #3;
    bus.iValue = {$urandom(), $urandom()};
    iReset = 1'b1;
    #1;
    check("reset_async_clear", int'(bus.oLights), 0);
    repeat (3) @(negedge iClk);
    iReset = 1'b0;
    model_reset();
    for (int c = 0; c < CH; c++) cur[c] = 0;
    repeat (4) step('0, 16'h5555, 4'hF);
    random_steps(60);

    @(posedge iClk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
